multi_lane_reg_fifo: RTL and testbench

Register-based synchronous FIFO that moves a variable number of words per cycle on each side: up to IN_LANES words pushed and up to OUT_LANES words popped per handshake. It succeeds the single-word register FIFO in width/lane handling while keeping first-word-fall-through reads and the same clear/count semantics. It adds almost-full/almost-empty flags and a sticky protocol-error flag. It sits between lane-parallel producers and consumers, for example the interleaving stages, where per-cycle word counts differ between the two sides.

---
 rtl/multi_lane_reg_fifo_pkg.sv | 20 ++
 rtl/multi_lane_reg_fifo_gather.sv | 32 +++
 rtl/multi_lane_reg_fifo.sv | 131 +++++++++++++
 tb/tb_multi_lane_reg_fifo.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_lane_reg_fifo_pkg.sv
// Shared helpers for the multi-lane register FIFO.
// Pointer arithmetic assumes a power-of-two depth.
package multi_lane_fifo_pkg;

    function automatic int unsigned umin(
        input int unsigned a,
        input int unsigned b
    );
        return (a < b) ? a : b;
    endfunction

    function automatic int unsigned wrap_add(
        input int unsigned ptr,
        input int unsigned n,
        input int unsigned depth
    );
        return (ptr + n) & (depth - 1);
    endfunction

endpackage

// File: rtl/multi_lane_reg_fifo_gather.sv
// Read-side lane mux: lane i shows storage[raddr+i].
// Lanes at or beyond out_num are forced to zero.
module lane_gather
    import multi_lane_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int OUT_LANES  = 2,
    parameter int LB_DEPTH   = $clog2(FIFO_DEPTH),
    parameter int OUT_NW     = $clog2(OUT_LANES + 1)
) (
    input  logic [DATA_WIDTH-1:0]           storage [FIFO_DEPTH],
    input  logic [LB_DEPTH-1:0]             raddr,
    input  logic [OUT_NW-1:0]               out_num,
    output logic [OUT_LANES*DATA_WIDTH-1:0] out_data
);

    logic [LB_DEPTH-1:0] idx;

    // Gather head words with wrap, masking unused lanes.
    always_comb begin
        out_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < OUT_LANES; i++) begin
            if (i < 32'(out_num)) begin
                idx = LB_DEPTH'(wrap_add(32'(raddr), i, FIFO_DEPTH));
                out_data[i*DATA_WIDTH +: DATA_WIDTH] = storage[idx];
            end
        end
    end

endmodule

// File: rtl/multi_lane_reg_fifo.sv
// Register FIFO with variable words per push and per pop.
// First-word fall-through; registered almost flags; sticky err.
module multi_lane_reg_fifo
    import multi_lane_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int IN_LANES   = 2,
    parameter int OUT_LANES  = 2,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    localparam int LB_DEPTH  = $clog2(FIFO_DEPTH),
    localparam int IN_NW     = $clog2(IN_LANES + 1),
    localparam int OUT_NW    = $clog2(OUT_LANES + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IN_LANES*DATA_WIDTH-1:0]  in_data,
    input  logic [IN_NW-1:0]                in_num,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [OUT_LANES*DATA_WIDTH-1:0] out_data,
    output logic [OUT_NW-1:0]               out_num,
    output logic                            out_valid,
    input  logic [OUT_NW-1:0]               out_req,
    input  logic                            out_ready,
    input  logic                            clear,
    output logic [LB_DEPTH:0]               count,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic                            err
);

    localparam int CW = LB_DEPTH + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] slot_wd [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_we;
    logic [LB_DEPTH-1:0]   waddr, raddr, slot;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [IN_NW-1:0]      npush;
    logic [OUT_NW-1:0]     npop;
    logic                  in_legal, out_legal;
    logic                  in_exec, out_exec, proto_err;
    logic                  err_q, af_q, ae_q;

    // Handshake qualification and occupancy arithmetic.
    always_comb begin
        in_legal  = (in_num != '0) && (32'(in_num) <= IN_LANES);
        out_legal = (out_req != '0) && (32'(out_req) <= OUT_LANES);
        out_valid = (cnt != '0);
        out_num   = OUT_NW'(umin(32'(cnt), OUT_LANES));
        in_ready  = !rst && in_legal
                  && (32'(in_num) <= FIFO_DEPTH - 32'(cnt));
        in_exec   = in_valid && in_ready;
        out_exec  = out_valid && out_ready && out_legal;
        proto_err = (in_valid && !in_legal)
                  || (out_valid && out_ready && !out_legal);
        npush     = in_exec ? in_num : '0;
        npop      = out_exec
                  ? OUT_NW'(umin(32'(out_req), 32'(out_num))) : '0;
        cnt_nx    = clear ? '0 : cnt + CW'(npush) - CW'(npop);
    end

    // Per-slot write-enable decode for the pushed lanes.
    always_comb begin
        slot_we = '0;
        slot    = '0;
        for (int s = 0; s < FIFO_DEPTH; s++) slot_wd[s] = '0;
        for (int unsigned i = 0; i < IN_LANES; i++) begin
            if (in_exec && !clear && i < 32'(in_num)) begin
                slot = LB_DEPTH'(wrap_add(32'(waddr), i, FIFO_DEPTH));
                slot_we[slot] = 1'b1;
                slot_wd[slot] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Storage is never cleared; only written slots change.
    always_ff @(posedge clk) begin
        for (int s = 0; s < FIFO_DEPTH; s++) begin
            if (slot_we[s]) mem[s] <= slot_wd[s];
        end
    end

    // Pointers, occupancy, flags and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr <= '0;
            raddr <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
            af_q  <= 1'b0;
            ae_q  <= 1'b1;
        end else begin
            af_q <= (32'(cnt_nx) >= AF_LEVEL);
            ae_q <= (32'(cnt_nx) <= AE_LEVEL);
            cnt  <= cnt_nx;
            if (clear) begin
                waddr <= '0;
                raddr <= '0;
                err_q <= 1'b0;
            end else begin
                waddr <= LB_DEPTH'(wrap_add(32'(waddr), 32'(npush),
                                            FIFO_DEPTH));
                raddr <= LB_DEPTH'(wrap_add(32'(raddr), 32'(npop),
                                            FIFO_DEPTH));
                if (proto_err) err_q <= 1'b1;
            end
        end
    end

    lane_gather #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .OUT_LANES  (OUT_LANES),
        .LB_DEPTH   (LB_DEPTH),
        .OUT_NW     (OUT_NW)
    ) u_gather (
        .storage  (mem),
        .raddr    (raddr),
        .out_num  (out_num),
        .out_data (out_data)
    );

    assign count        = cnt;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign err          = err_q;

endmodule

// File: tb/tb_multi_lane_reg_fifo.sv
// Directed bench for multi_lane_reg_fifo (DEPTH 8, 2 in / 2 out lanes).
// Inputs change 2ns after the rising edge; checks run 1ns later.
module tb_multi_lane_reg_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [1:0]  in_num;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [1:0]  out_num;
    logic        out_valid;
    logic [1:0]  out_req;
    logic        out_ready;
    logic        clear;
    logic [3:0]  count;
    logic        almost_full;
    logic        almost_empty;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_lane_reg_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_num       (in_num),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_num      (out_num),
        .out_valid    (out_valid),
        .out_req      (out_req),
        .out_ready    (out_ready),
        .clear        (clear),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_num    = 2'd0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        out_req   = 2'd0;
        clear     = 1'b0;
    endtask

    task automatic push(input logic [1:0] n, input logic [15:0] d);
        in_valid = 1'b1;
        in_num   = n;
        in_data  = d;
        tick();
        idle();
    endtask

    task automatic pop(input logic [1:0] n);
        out_ready = 1'b1;
        out_req   = n;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_num   = 2'd1;
        #3;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready got %b exp 0", in_ready);
        end
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || out_num !== 2'd0) begin
            errors++;
            $display("FAIL rst_count got %0d/%b/%0d exp 0/0/0",
                     count, out_valid, out_num);
        end
        checks++;
        if (almost_empty !== 1'b1 || almost_full !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got ae%b af%b err%b exp ae1 af0 err0",
                     almost_empty, almost_full, err);
        end
        checks++;
        if (out_data !== 16'h0) begin
            errors++;
            $display("FAIL rst_out_data got %h exp 0000", out_data);
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_in_ready got %b exp 1", in_ready);
        end
        idle();
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_num   = 2'd2;
            in_data  = {8'(2*k+2), 8'(2*k+1)};
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready%0d got %b exp 1", k, in_ready);
            end
            tick();
        end
        in_data = 16'hA090;
        #1;
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got cnt%0d rdy%b exp cnt8 rdy0",
                     count, in_ready);
        end
        checks++;
        if (almost_full !== 1'b1 || almost_empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_flags got af%b ae%b exp af1 ae0",
                     almost_full, almost_empty);
        end
        tick();
        in_num = 2'd1;
        #1;
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0 || out_data !== 16'h0201) begin
            errors++;
            $display("FAIL fill_refused got cnt%0d rdy%b data%h exp cnt8 rdy0 data0201",
                     count, in_ready, out_data);
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b1;
            out_req   = 2'd2;
            #1;
            checks++;
            if (out_data !== {8'(2*k+2), 8'(2*k+1)} || out_num !== 2'd2) begin
                errors++;
                $display("FAIL drain%0d got %h/%0d exp %h/2", k, out_data,
                         out_num, {8'(2*k+2), 8'(2*k+1)});
            end
            tick();
        end
        idle();
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got cnt%0d v%b ae%b exp cnt0 v0 ae1",
                     count, out_valid, almost_empty);
        end
    endtask

    task automatic test_partial_read();
        push(2'd2, 16'h0201);
        push(2'd1, 16'h0003);
        checks++;
        if (count !== 4'd3 || almost_empty !== 1'b0) begin
            errors++;
            $display("FAIL part_cnt got cnt%0d ae%b exp cnt3 ae0",
                     count, almost_empty);
        end
        out_ready = 1'b1;
        out_req   = 2'd2;
        #1;
        checks++;
        if (out_data !== 16'h0201 || out_num !== 2'd2) begin
            errors++;
            $display("FAIL part_lanes got %h/%0d exp 0201/2", out_data, out_num);
        end
        tick();
        #1;
        checks++;
        if (count !== 4'd1 || out_num !== 2'd1 || out_data !== 16'h0003) begin
            errors++;
            $display("FAIL part_tail got cnt%0d n%0d data%h exp cnt1 n1 data0003",
                     count, out_num, out_data);
        end
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || out_data !== 16'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL part_empty got cnt%0d data%h err%b exp 0/0000/0",
                     count, out_data, err);
        end
    endtask

    task automatic test_wrap();
        push(2'd2, 16'h3130);
        push(2'd2, 16'h3332);
        pop(2'd2);
        pop(2'd2);
        push(2'd2, 16'hBBAA);
        checks++;
        if (count !== 4'd2 || out_data !== 16'hBBAA) begin
            errors++;
            $display("FAIL wrap_data got cnt%0d data%h exp cnt2 dataBBAA",
                     count, out_data);
        end
        pop(2'd2);
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_empty got cnt%0d v%b exp 0/0", count, out_valid);
        end
    endtask

    task automatic test_simultaneous();
        push(2'd2, 16'h1110);
        push(2'd2, 16'h1312);
        push(2'd2, 16'h1514);
        push(2'd1, 16'h0016);
        checks++;
        if (count !== 4'd7 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL sim_cnt got cnt%0d af%b exp cnt7 af1",
                     count, almost_full);
        end
        in_valid  = 1'b1;
        in_num    = 2'd2;
        in_data   = 16'h1817;
        out_ready = 1'b1;
        out_req   = 2'd2;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL sim_no_credit got %b exp 0", in_ready);
        end
        in_num = 2'd1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_data !== 16'h1110) begin
            errors++;
            $display("FAIL sim_one got rdy%b data%h exp rdy1 data1110",
                     in_ready, out_data);
        end
        tick();
        idle();
        checks++;
        if (count !== 4'd6 || out_data !== 16'h1312) begin
            errors++;
            $display("FAIL sim_after got cnt%0d data%h exp cnt6 data1312",
                     count, out_data);
        end
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_num    = 2'd2;
        out_ready = 1'b1;
        out_req   = 2'd2;
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL sim_clear got cnt%0d v%b af%b exp 0/0/0",
                     count, out_valid, almost_full);
        end
    endtask

    task automatic test_proto_err();
        push(2'd1, 16'h0055);
        in_valid = 1'b1;
        in_num   = 2'd0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_ready got %b exp 0", in_ready);
        end
        tick();
        idle();
        checks++;
        if (err !== 1'b1 || count !== 4'd1) begin
            errors++;
            $display("FAIL err_in0 got err%b cnt%0d exp err1 cnt1", err, count);
        end
        clear = 1'b1;
        tick();
        idle();
        checks++;
        if (err !== 1'b0 || count !== 4'd0 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL err_clear got err%b cnt%0d ae%b exp 0/0/1",
                     err, count, almost_empty);
        end
        push(2'd2, 16'h6766);
        pop(2'd3);
        checks++;
        if (err !== 1'b1 || count !== 4'd2 || out_data !== 16'h6766) begin
            errors++;
            $display("FAIL err_req3 got err%b cnt%0d data%h exp 1/2/6766",
                     err, count, out_data);
        end
        in_valid = 1'b1;
        in_num   = 2'd3;
        in_data  = 16'h7777;
        tick();
        idle();
        checks++;
        if (count !== 4'd2 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_in3 got cnt%0d err%b exp 2/1", count, err);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_partial_read();
        test_wrap();
        test_simultaneous();
        test_proto_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
